// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide synchronous memory between fetch and load/store ports,
// sequencing each 32-bit little-endian word request as four byte accesses.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter bit PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_done,
    output logic [31:0]       dm_rdata,
    output logic              busy,
    output logic              gnt_dm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    typedef enum logic [1:0] {IDLE, XFER, FIN, DONE} state_t;
    state_t state, state_n;
    logic [1:0] cnt;
    logic owner, we, req, pick_dm, unused_addr;
    logic [ADDR_W-1:0] base;
    logic [31:0] wdata, rdata;
    assign req = if_req | dm_req;
    // owner doubles as the round-robin pointer: a tie goes to dm only if fetch was served last
    assign pick_dm = dm_req & (~if_req | ~PRIORITY | ~owner);
    assign unused_addr = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            owner <= 1'b0;
            we    <= 1'b0;
            base  <= '0;
            wdata <= 32'h0;
            rdata <= 32'h0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                owner <= pick_dm;
                we    <= pick_dm & dm_we;
                base  <= pick_dm ? dm_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
                wdata <= dm_wdata;
                cnt   <= 2'd0;
            end
            if (state == XFER)
                cnt <= cnt + 2'd1;
            // read bytes arrive one cycle after their address, so byte k lands during cnt k+1 or FIN
            if (state == XFER && !we && cnt != 2'd0)
                rdata[{cnt - 2'd1, 3'b000} +: 8] <= mem_rdata;
            if (state == FIN)
                rdata[31:24] <= mem_rdata;
        end
    end
    always_comb
        state_n = state == IDLE ? (req ? XFER : IDLE)
                : state == XFER ? (cnt != 2'd3 ? XFER : we ? DONE : FIN)
                : state == FIN  ? DONE : IDLE;
    always_comb begin
        busy      = state != IDLE;
        gnt_dm    = owner;
        if_done   = state == DONE && !owner;
        dm_done   = state == DONE && owner;
        mem_addr  = base + ADDR_W'(cnt);
        mem_we    = state == XFER && we;
        mem_wdata = mem_we ? wdata[{cnt, 3'b000} +: 8] : 8'h00;
        if_rdata  = rdata;
        dm_rdata  = rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, multi-cycle corner sequences and randomized word
// traffic checked against a byte-array memory model, for both tie-break policies.
module tb_mem_port_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, if_req1 = 1'b0, dm_req1 = 1'b0;
    logic [31:0] if_addr = 32'h0, dm_addr = 32'h0, dm_wdata = 32'h0;
    logic if_done, dm_done, busy, gnt_dm, mem_we;
    logic [31:0] if_rdata, dm_rdata;
    logic [15:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic if_done1, dm_done1, busy1, gnt_dm1, mem_we1;
    logic [31:0] if_rdata1, dm_rdata1;
    logic [15:0] mem_addr1;
    logic [7:0] mem_wdata1, mem_rdata1;
    logic [7:0] mem0 [0:65535];
    logic [7:0] mem1 [0:65535];
    logic [7:0] ref_mem [0:65535];
    int checks = 0, errors = 0;
    logic [31:0] last_read = 32'h0;

    typedef struct {
        logic        d;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .PRIORITY(1'b0)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata), .busy(busy),
        .gnt_dm(gnt_dm), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(16), .PRIORITY(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr), .if_done(if_done1),
        .if_rdata(if_rdata1), .dm_req(dm_req1), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_done(dm_done1), .dm_rdata(dm_rdata1), .busy(busy1),
        .gnt_dm(gnt_dm1), .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    always @(posedge clk) begin
        if (mem_we) mem0[mem_addr] <= mem_wdata;
        mem_rdata <= mem0[mem_addr];
        if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
        mem_rdata1 <= mem1[mem_addr1];
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [15:0] a);
        return {ref_mem[a + 16'd3], ref_mem[a + 16'd2], ref_mem[a + 16'd1], ref_mem[a]};
    endfunction

    task automatic ref_write(input logic [15:0] a, input logic [31:0] wd);
        for (int i = 0; i < 4; i++) ref_mem[a + 16'(i)] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {mem0[a + 16'd3], mem0[a + 16'd2], mem0[a + 16'd1], mem0[a]};
    endfunction

    // one request on dut; request fields are scrambled after sampling to prove they are latched
    task automatic txn(input logic d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input int exp_lat, input string nm);
        int lat;
        logic [31:0] got;
        logic bad_seq, bad_other;
        lat = 0; got = 32'h0; bad_seq = 1'b0; bad_other = 1'b0;
        @(negedge clk);
        if (d) begin
            dm_req = 1'b1; dm_we = w; dm_addr = a; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (gnt_dm !== d) bad_seq = 1'b1;
                if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom);
            end
            if (c <= 4 && (mem_addr !== a[15:0] + 16'(c - 1) || mem_we !== w ||
                           (w && mem_wdata !== wd[8*(c-1) +: 8]))) bad_seq = 1'b1;
            if (d ? if_done : dm_done) bad_other = 1'b1;
            if (d ? dm_done : if_done) begin
                lat = c;
                got = d ? dm_rdata : if_rdata;
            end
        end
        dm_req = 1'b0; if_req = 1'b0;
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " rdata"}, got, exp);
        check({nm, " byte sequence"}, {31'h0, bad_seq}, 32'h0);
        check({nm, " other done"}, {31'h0, bad_other}, 32'h0);
        if (w) check({nm, " memory"}, mem_word(a[15:0]), wd);
    endtask

    initial begin
        int t_dm, t_if, n, k;
        int t [3];
        logic g1, g7, no_done, idle_ok, d, w;
        logic [31:0] r_if, a, wd, exp;
        logic [3:0] order;
        for (int i = 0; i < 65536; i++) begin
            mem0[i] = 8'($urandom);
            mem1[i] = mem0[i];
            ref_mem[i] = mem0[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem0[16'h0010 + 16'(i)] = 8'h10 + 8'(i);
            mem0[16'hFFFE + 16'(i)] = 8'hA0 + 8'(i);
            mem0[16'h0040 + 16'(i)] = 8'h00;
            mem1[16'h0010 + 16'(i)] = 8'h10 + 8'(i);
            ref_mem[16'h0010 + 16'(i)] = 8'h10 + 8'(i);
            ref_mem[16'hFFFE + 16'(i)] = 8'hA0 + 8'(i);
            ref_mem[16'h0040 + 16'(i)] = 8'h00;
        end
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h1312_1110, 6};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h1312_1110, 5};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 6};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_FFFE, 32'h0, 32'hA3A2_A1A0, 6};
        tbl[4] = '{1'b0, 1'b0, 32'hABCD_0010, 32'h0, 32'h1312_1110, 6};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_FFFF, 32'h0102_0304, 32'h1312_1110, 5};
        tbl[6] = '{1'b0, 1'b0, 32'h0000_FFFF, 32'h0, 32'h0102_0304, 6};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset gnt_dm", {31'h0, gnt_dm}, 32'h0);
        check("reset dones", {30'h0, if_done, dm_done}, 32'h0);
        check("reset mem_we", {31'h0, mem_we}, 32'h0);
        check("reset mem_addr", {16'h0, mem_addr}, 32'h0);
        check("reset mem_wdata", {24'h0, mem_wdata}, 32'h0);
        check("reset rdata", if_rdata, 32'h0);

        for (int i = 0; i < 7; i++) begin
            txn(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].exp, tbl[i].lat, $sformatf("vec%0d", i));
            if (tbl[i].w) ref_write(tbl[i].a[15:0], tbl[i].wd);
        end

        // tie under fixed priority: dm write first, fetch after one IDLE cycle
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h30; dm_wdata = 32'h55AA_1234;
        t_dm = 0; t_if = 0; g1 = 1'b0; g7 = 1'b1; r_if = 32'h0;
        for (int c = 1; c <= 40 && (t_dm == 0 || t_if == 0); c++) begin
            @(negedge clk);
            if (c == 1) g1 = gnt_dm;
            if (c == 7) g7 = gnt_dm;
            if (dm_done) begin t_dm = c; dm_req = 1'b0; end
            if (if_done) begin t_if = c; r_if = if_rdata; if_req = 1'b0; end
        end
        dm_req = 1'b0; if_req = 1'b0;
        check("tie dm done cycle", t_dm, 5);
        check("tie if done cycle", t_if, 12);
        check("tie first grant", {31'h0, g1}, 32'h1);
        check("tie second grant", {31'h0, g7}, 32'h0);
        check("tie if rdata", r_if, 32'h1312_1110);
        ref_write(16'h30, 32'h55AA_1234);
        check("tie dm memory", mem_word(16'h30), 32'h55AA_1234);

        // reset after two write bytes
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h4433_2211;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort mem_we", {31'h0, mem_we}, 32'h0);
        check("abort mem_addr", {16'h0, mem_addr}, 32'h0);
        check("abort rdata", dm_rdata, 32'h0);
        rst = 1'b0; dm_req = 1'b0;
        no_done = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (dm_done || if_done || busy) no_done = 1'b0;
        end
        check("abort no done", {31'h0, no_done}, 32'h1);
        check("abort partial write", mem_word(16'h40), 32'h0000_2211);
        ref_mem[16'h40] = 8'h11; ref_mem[16'h41] = 8'h22;
        last_read = 32'h0;

        // fetch held high: back-to-back fetches with one IDLE cycle between
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        n = 0; idle_ok = 1'b1; t = '{0, 0, 0};
        for (int c = 1; c <= 40 && n < 3; c++) begin
            @(negedge clk);
            if ((c == 7 || c == 14) && (busy || if_done)) idle_ok = 1'b0;
            if (if_done) begin
                t[n] = c; n++;
                if (if_rdata !== 32'h1312_1110) idle_ok = 1'b0;
            end
        end
        if_req = 1'b0;
        check("b2b count", n, 3);
        check("b2b done 1", t[0], 6);
        check("b2b done 2", t[1], 13);
        check("b2b done 3", t[2], 20);
        check("b2b idle gap and data", {31'h0, idle_ok}, 32'h1);
        last_read = 32'h1312_1110;

        // round-robin instance with both requesters held high
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if_addr = 32'h10; dm_addr = 32'h20; dm_we = 1'b0;
        if_req1 = 1'b1; dm_req1 = 1'b1;
        n = 0; order = 4'h0;
        for (int c = 1; c <= 80 && n < 4; c++) begin
            @(negedge clk);
            if (dm_done1 || if_done1) begin order[n] = dm_done1; n++; end
        end
        if_req1 = 1'b0; dm_req1 = 1'b0;
        check("rr done count", n, 4);
        check("rr grant order", {28'h0, order}, 32'h5);
        last_read = 32'h0;

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 2);
            d = k != 0; w = k == 2;
            a = $urandom; wd = $urandom;
            exp = w ? last_read : ref_word(a[15:0]);
            txn(d, w, a, wd, exp, w ? 5 : 6, $sformatf("rnd%0d", i));
            if (w) ref_write(a[15:0], wd);
            else last_read = exp;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
